// File: rtl/decode_accum.sv
// Streaming index decoder: each beat decodes to a one-hot / thermometer / inverse
// thermometer mask, OR-accumulated across a burst and emitted once per burst.
module decode_accum #(
    parameter int Width    = 8,
    parameter int MaxBeats = 16,
    localparam int IdxW    = $clog2(Width),
    localparam int CntW    = $clog2(MaxBeats + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IdxW-1:0]  in_idx_i,
    input  logic [1:0]       in_mode_i,
    input  logic             in_last_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_mask_o,
    output logic [CntW-1:0]  out_cnt_o,
    output logic             out_err_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    // Handshake: a beat (input) or burst (output) transfers on a rising clock edge
    // where valid and ready are both high; valid never waits on ready.

    localparam logic [IdxW:0]   WidthExt = (IdxW + 1)'(Width);
    localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxBeats);

    localparam logic [1:0] ModeThermo    = 2'd1;
    localparam logic [1:0] ModeInvThermo = 2'd2;

    // IDLE means the next accepted beat is the first beat of a burst.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [Width-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [Width-1:0]   out_mask_q, out_mask_d;
    logic [CntW-1:0]    out_cnt_q, out_cnt_d;
    logic               out_err_q, out_err_d;
    logic               out_valid_q, out_valid_d;

    logic [1:0]         mode_eff;
    logic               oor;
    logic [Width-1:0]   dec;
    logic               beat_ok;
    logic [Width-1:0]   mask_next;
    logic [CntW-1:0]    cnt_inc;
    logic               err_next;

    // A single-beat burst uses its own mode because the latch is only consulted in ACCUM.
    assign mode_eff = (state_q == IDLE) ? in_mode_i : mode_q;

    always_comb begin
        oor = ({1'b0, in_idx_i} >= WidthExt);
        dec = '0;
        for (int i = 0; i < Width; i++) begin
            case (mode_eff)
                ModeThermo:    dec[i] = (IdxW'(i) <= in_idx_i);
                ModeInvThermo: dec[i] = (IdxW'(i) >= in_idx_i);
                default:       dec[i] = (IdxW'(i) == in_idx_i);
            endcase
        end
        // An out-of-range index must not contribute, even in thermometer mode.
        if (oor) begin
            dec = '0;
        end
    end

    // Last beats need the output slot free (or draining this cycle); others never stall.
    assign in_ready_o = !in_last_i || !out_valid_q || out_ready_i;
    assign beat_ok    = in_valid_i && in_ready_o;

    assign mask_next = acc_q | dec;
    assign cnt_inc   = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + CntW'(1);
    assign err_next  = err_q | oor;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_mask_d  = out_mask_q;
        out_cnt_d   = out_cnt_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        if (beat_ok && !in_last_i) begin
            acc_d   = mask_next;
            cnt_d   = cnt_inc;
            err_d   = err_next;
            state_d = ACCUM;
            if (state_q == IDLE) begin
                mode_d = in_mode_i;
            end
        end

        if (beat_ok && in_last_i) begin
            out_mask_d  = mask_next;
            out_cnt_d   = cnt_inc;
            out_err_d   = err_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            mode_d      = '0;
            state_d     = IDLE;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_mask_q  <= '0;
            out_cnt_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_mask_q  <= out_mask_d;
            out_cnt_q   <= out_cnt_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_mask_o  = out_mask_q;
    assign out_cnt_o   = out_cnt_q;
    assign out_err_o   = out_err_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_decode_accum.sv
// Bench for decode_accum: directed vector table, hand-written corner sequences
// (Width=6 out-of-range, count saturation, async reset) and a randomized run.
module tb_decode_accum;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Width=8 instance
    logic [2:0] idx8;
    logic [1:0] mode8;
    logic       last8, valid8, ordy8;
    logic       rdy8, ov8, err8;
    logic [7:0] mask8;
    logic [4:0] cnt8;

    // Width=6 instance
    logic [2:0] idx6;
    logic [1:0] mode6;
    logic       last6, valid6, ordy6;
    logic       rdy6, ov6, err6;
    logic [5:0] mask6;
    logic [4:0] cnt6;

    decode_accum #(.Width(8), .MaxBeats(16)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_idx_i(idx8), .in_mode_i(mode8), .in_last_i(last8), .in_valid_i(valid8),
        .in_ready_o(rdy8),
        .out_mask_o(mask8), .out_cnt_o(cnt8), .out_err_o(err8), .out_valid_o(ov8),
        .out_ready_i(ordy8)
    );

    decode_accum #(.Width(6), .MaxBeats(16)) dut6 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_idx_i(idx6), .in_mode_i(mode6), .in_last_i(last6), .in_valid_i(valid6),
        .in_ready_o(rdy6),
        .out_mask_o(mask6), .out_cnt_o(cnt6), .out_err_o(err6), .out_valid_o(ov6),
        .out_ready_i(ordy6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] idx;
        logic [1:0] mode;
        logic       last;
        logic       valid;
        logic       ordy;
        logic       e_rdy;
        logic       e_valid;
        logic [7:0] e_mask;
        logic [4:0] e_cnt;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(int idx, int mode, int last, int valid, int ordy,
                                int e_rdy, int e_valid, int e_mask, int e_cnt, int e_err);
        vec_t v;
        v.idx = 3'(idx); v.mode = 2'(mode); v.last = 1'(last); v.valid = 1'(valid);
        v.ordy = 1'(ordy); v.e_rdy = 1'(e_rdy); v.e_valid = 1'(e_valid);
        v.e_mask = 8'(e_mask); v.e_cnt = 5'(e_cnt); v.e_err = 1'(e_err);
        return v;
    endfunction

    vec_t vecs[16];

    // Drive one cycle on dut8 (inputs set just after a rising edge), check ready mid-cycle,
    // then outputs just after the next rising edge.
    task automatic apply8(input vec_t v, input int row);
        idx8 = v.idx; mode8 = v.mode; last8 = v.last; valid8 = v.valid; ordy8 = v.ordy;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", row), 32'(rdy8), 32'(v.e_rdy));
        @(posedge clk); #1;
        check($sformatf("vec%0d_out_valid", row), 32'(ov8), 32'(v.e_valid));
        if (v.e_valid) begin
            check($sformatf("vec%0d_mask", row), 32'(mask8), 32'(v.e_mask));
            check($sformatf("vec%0d_cnt", row), 32'(cnt8), 32'(v.e_cnt));
            check($sformatf("vec%0d_err", row), 32'(err8), 32'(v.e_err));
        end
    endtask

    task automatic beat6(input int idx, input int mode, input int last);
        idx6 = 3'(idx); mode6 = 2'(mode); last6 = 1'(last); valid6 = 1'b1; ordy6 = 1'b1;
        @(posedge clk); #1;
        valid6 = 1'b0; last6 = 1'b0;
    endtask

    // Reference model: beats of the open burst, plus the modelled output register.
    int         bq_idx[$];
    int         bq_mode[$];
    logic       m_valid;
    logic [31:0] m_mask;
    int         m_cnt;
    logic       m_err;

    // Burst result from first principles: the first beat's mode picks a bit range per index.
    function automatic void ref_burst(input int w, output logic [31:0] mask,
                                      output int cnt, output logic err);
        int m;
        mask = '0;
        err  = 1'b0;
        m    = bq_mode[0];
        foreach (bq_idx[k]) begin
            int a;
            a = bq_idx[k];
            if (a >= w) err = 1'b1;
            else if (m == 1) mask |= (32'd1 << (a + 1)) - 32'd1;
            else if (m == 2) mask |= ((32'd1 << w) - 32'd1) & ~((32'd1 << a) - 32'd1);
            else mask |= 32'd1 << a;
        end
        cnt = (bq_idx.size() > 16) ? 16 : bq_idx.size();
    endfunction

    initial begin
        rst_n = 1'b0;
        idx8 = '0; mode8 = '0; last8 = 1'b0; valid8 = 1'b0; ordy8 = 1'b1;
        idx6 = '0; mode6 = '0; last6 = 1'b0; valid6 = 1'b0; ordy6 = 1'b1;

        //            idx mode last vld ordy | rdy vld mask  cnt err
        vecs[0]  = mk(5, 0, 1, 1, 1,   1, 1, 8'h20, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1,   1, 0, 0,     0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 1,   1, 0, 0,     0, 0);
        vecs[3]  = mk(3, 0, 0, 1, 1,   1, 0, 0,     0, 0);
        vecs[4]  = mk(7, 0, 1, 1, 1,   1, 1, 8'h89, 3, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1,   1, 0, 0,     0, 0);
        vecs[6]  = mk(2, 1, 0, 1, 1,   1, 0, 0,     0, 0);
        vecs[7]  = mk(6, 0, 1, 1, 1,   1, 1, 8'h7F, 2, 0);
        vecs[8]  = mk(1, 0, 0, 1, 0,   1, 1, 8'h7F, 2, 0);
        vecs[9]  = mk(4, 0, 1, 1, 0,   0, 1, 8'h7F, 2, 0);
        vecs[10] = mk(4, 0, 1, 1, 1,   1, 1, 8'h12, 2, 0);
        vecs[11] = mk(0, 0, 0, 0, 1,   1, 0, 0,     0, 0);
        vecs[12] = mk(2, 3, 1, 1, 1,   1, 1, 8'h04, 1, 0);
        vecs[13] = mk(7, 1, 1, 1, 1,   1, 1, 8'hFF, 1, 0);
        vecs[14] = mk(3, 2, 1, 1, 1,   1, 1, 8'hF8, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 1,   1, 0, 0,     0, 0);

        // Reset state
        #12;
        check("reset_out_valid", 32'(ov8), 32'd0);
        check("reset_mask", 32'(mask8), 32'd0);
        check("reset_cnt", 32'(cnt8), 32'd0);
        check("reset_err", 32'(err8), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 16; r++) apply8(vecs[r], r);

        // Width=6: out-of-range index in inverse thermometer contributes nothing but flags error
        beat6(6, 2, 0);
        check("w6_no_early_valid", 32'(ov6), 32'd0);
        beat6(3, 0, 1);
        check("w6_oor_valid", 32'(ov6), 32'd1);
        check("w6_oor_mask", 32'(mask6), 32'h38);
        check("w6_oor_cnt", 32'(cnt6), 32'd2);
        check("w6_oor_err", 32'(err6), 32'd1);
        // Thermometer must not turn an out-of-range index into all-ones
        beat6(7, 1, 1);
        check("w6_thermo_oor_mask", 32'(mask6), 32'd0);
        check("w6_thermo_oor_err", 32'(err6), 32'd1);
        check("w6_thermo_oor_cnt", 32'(cnt6), 32'd1);
        // 20-beat burst saturates the count
        for (int i = 0; i < 20; i++) beat6(i % 6, 0, (i == 19) ? 1 : 0);
        check("w6_sat_cnt", 32'(cnt6), 32'd16);
        check("w6_sat_mask", 32'(mask6), 32'h3F);
        check("w6_sat_err", 32'(err6), 32'd0);
        @(posedge clk); #1;
        check("w6_drain", 32'(ov6), 32'd0);

        // Async reset mid-burst while an output is held
        idx8 = 3'd5; mode8 = 2'd0; last8 = 1'b1; valid8 = 1'b1; ordy8 = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_valid", 32'(ov8), 32'd1);
        last8 = 1'b0; idx8 = 3'd2;
        @(posedge clk); #1;
        idx8 = 3'd3;
        @(posedge clk); #1;
        valid8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(ov8), 32'd0);
        check("rst_async_mask", 32'(mask8), 32'd0);
        check("rst_async_cnt", 32'(cnt8), 32'd0);
        check("rst_async_err", 32'(err8), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idx8 = 3'd1; mode8 = 2'd0; last8 = 1'b1; valid8 = 1'b1; ordy8 = 1'b1;
        @(posedge clk); #1;
        check("rst_after_mask", 32'(mask8), 32'h02);
        check("rst_after_cnt", 32'(cnt8), 32'd1);
        check("rst_after_err", 32'(err8), 32'd0);
        valid8 = 1'b0; last8 = 1'b0;
        @(posedge clk); #1;

        // Randomized run against the reference model
        m_valid = 1'b0; m_mask = '0; m_cnt = 0; m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic e_rdy, acc;
            idx8   = 3'($urandom_range(0, 7));
            mode8  = 2'($urandom_range(0, 3));
            valid8 = ($urandom_range(0, 3) != 0);
            last8  = ($urandom_range(0, 2) == 0);
            ordy8  = ($urandom_range(0, 2) != 0);
            e_rdy  = !last8 || !m_valid || ordy8;
            acc    = valid8 && e_rdy;
            @(negedge clk);
            check("rand_in_ready", 32'(rdy8), 32'(e_rdy));
            @(posedge clk); #1;
            if (acc) begin
                bq_idx.push_back(int'(idx8));
                bq_mode.push_back(int'(mode8));
            end
            if (acc && last8) begin
                ref_burst(8, m_mask, m_cnt, m_err);
                bq_idx.delete();
                bq_mode.delete();
                m_valid = 1'b1;
            end else if (ordy8) begin
                m_valid = 1'b0;
            end
            check("rand_out_valid", 32'(ov8), 32'(m_valid));
            if (m_valid) begin
                check("rand_mask", 32'(mask8), m_mask);
                check("rand_cnt", 32'(cnt8), 32'(m_cnt));
                check("rand_err", 32'(err8), 32'(m_err));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_accum.md
Name: decode_accum

Overview:
- Sequential, handshaked successor to the combinational binary-to-one-hot decoder.
- Accepts a stream of binary indices, decodes each beat into a Width-bit mask (one-hot, thermometer or inverse thermometer), and OR-accumulates the masks across a burst terminated by in_last_i.
- Presents one registered mask per burst, with beat count and error flag, on a valid/ready output.
- Used to build bank/lane enable masks from multi-beat index streams.

Parameters:
- Width, 8, output mask width; must be >= 2; need not be a power of two.
- MaxBeats, 16, saturation value of the beat counter; must be >= 1.
- IdxW (localparam), $clog2(Width), index width.
- CntW (localparam), $clog2(MaxBeats+1), beat count width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_idx_i  in  IdxW  binary index of current beat
- in_mode_i  in  2  decode mode: 0 one-hot, 1 thermometer, 2 inverse thermometer, 3 reserved (decodes as one-hot)
- in_last_i  in  1  marks final beat of burst
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- out_mask_o  out  Width  accumulated mask of completed burst
- out_cnt_o  out  CntW  number of beats in burst, saturating at MaxBeats
- out_err_o  out  1  at least one beat in burst had in_idx_i >= Width
- out_valid_o  out  1  output holds a completed burst
- out_ready_i  in  1  downstream accepts output

Behaviour:
- Reset (asynchronous, rst_ni=0): out_valid_o=0, out_mask_o=0, out_cnt_o=0, out_err_o=0. Accumulator mask, count, error, latched mode and first-beat flag all cleared. A reset mid-burst discards the partial burst; no output is produced for it.
- Decode per beat, with A=in_idx_i:
  - one-hot: bit A set.
  - thermometer: bits 0..A set.
  - inverse thermometer: bits A..Width-1 set.
  - If A >= Width (only possible when Width is not a power of two), the beat contributes all-zero and sets the burst error.
- Mode latch: the mode of the first beat of a burst applies to every beat of that burst. in_mode_i on later beats is ignored.
- Handshake:
  - Non-last beats: in_ready_o=1 unconditionally. The accumulator is independent of the output register.
  - Last beats: in_ready_o = !out_valid_o || out_ready_i. This is a combinational path from out_ready_i and is intentional.
  - Beat accepted = in_valid_i && in_ready_o.
- Accepted non-last beat:
  - acc <= acc | dec.
  - cnt <= min(cnt+1, MaxBeats).
  - err <= err | oor.
  - first-beat flag cleared.
- Accepted last beat:
  - out_mask_o <= acc | dec; out_cnt_o <= min(cnt+1, MaxBeats); out_err_o <= err | oor; out_valid_o <= 1.
  - Accumulator state cleared in the same cycle.
  - Latency: output valid the cycle after the last-beat handshake.
  - A single-beat burst (first beat also last) uses its own mode.
- Output handshake:
  - out_valid_o && out_ready_i clears out_valid_o, unless a last beat is accepted in the same cycle, in which case the new burst loads and out_valid_o stays 1.
  - Full throughput: one single-beat burst per cycle with out_ready_i=1.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_mask_o, out_cnt_o and out_err_o hold stable. Output data is not required to clear when out_valid_o drops.
- Stalled input: in_valid_i with a non-accepted last beat changes no state.
- Two-state control: ACCUM (first-beat flag=0) and IDLE (flag=1). IDLE->ACCUM on an accepted non-last beat; ACCUM->IDLE on an accepted last beat.

Test Plan:
- Width=8, mode 0, single beat A=5, last=1, out_ready=1 -> next cycle out_valid=1, mask=8'b0010_0000, cnt=1, err=0; following cycle out_valid=0.
- Mode 0, beats A=0,3,7 (last on third) -> mask=8'b1000_1001, cnt=3, single out_valid pulse.
- Beat 1 mode 1 A=2; beat 2 mode 0 A=6 last -> mode latched thermometer: mask=8'b0111_1111, cnt=2.
- out_ready=0 holding burst X; burst Y beats A=1 (non-last) accepted, last beat A=4 stalls with in_ready=0. Raise out_ready -> same cycle X drains and Y loads: mask=8'b0001_0010, out_valid stays 1.
- Width=6, mode 2: beat A=6 then A=3 last -> err=1, mask=6'b111000. 20-beat burst -> cnt=16 (MaxBeats).
- Assert rst_ni=0 asynchronously after 2 beats of a burst -> outputs 0 immediately. After release, single beat A=1 last -> mask=8'b0000_0010, cnt=1 (no residue).
